// File: rtl/cp0_pkg.sv
// Shared CP0 definitions for the exception context save/restore sequencer.
// Holds the state and direction encodings, context layout and stack bounds.
package cp0_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_SP,
    ST_PUSH,
    ST_POP,
    ST_WR_SP,
    ST_DONE
  } state_e;

  typedef enum logic {
    DIR_SAVE,
    DIR_RESTORE
  } dir_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned CTX_WORDS  = 3;
  localparam int unsigned CTX_BYTES  = 12;

  localparam logic [1:0] CTX_EPC    = 2'd0;
  localparam logic [1:0] CTX_STATUS = 2'd1;
  localparam logic [1:0] CTX_CAUSE  = 2'd2;

  localparam logic [31:0] STACK_LIMIT = 32'h0000_1000;
  localparam logic [31:0] STACK_TOP   = 32'h0000_2000;

endpackage

// File: rtl/ssp_addr_gen.sv
// Stack address, next-SSP and bounds-error decode for the context sequencer.
// Bounds/alignment checks exist only when SSP_BOUNDS_CHECK_EN is defined.
module ssp_addr_gen
  import cp0_pkg::*;
(
  input  logic [31:0] sp_i,
  input  logic [1:0]  idx_i,
  input  dir_e        dir_i,
  output logic [31:0] addr_o,
  output logic [31:0] new_sp_o,
  output logic        err_o
);

  logic [31:0] off;

  assign off = {28'd0, idx_i, 2'b00};

  // Save pushes downward below sp, restore pops upward from sp.
  always_comb begin
    addr_o   = sp_i + off;
    new_sp_o = sp_i + 32'(CTX_BYTES);
    if (dir_i == DIR_SAVE) begin
      addr_o   = sp_i - off - 32'(WORD_BYTES);
      new_sp_o = sp_i - 32'(CTX_BYTES);
    end
  end

`ifdef SSP_BOUNDS_CHECK_EN
  logic [32:0] sp33;
  logic        lo_err;
  logic        hi_err;

  assign sp33   = {1'b0, sp_i};
  assign lo_err = sp33 < ({1'b0, STACK_LIMIT} + 33'(CTX_BYTES));
  assign hi_err = (sp33 + 33'(CTX_BYTES)) > {1'b0, STACK_TOP};
  assign err_o  = (sp_i[1:0] != 2'b00)
                | ((dir_i == DIR_SAVE) ? lo_err : hi_err);
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: rtl/ssp_ctx_seq.sv
// Exception context save/restore sequencer in front of the CP0 SSP unit.
// Bounds checking is compiled in with SSP_BOUNDS_CHECK_EN.
module ssp_ctx_seq
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc_in,
  input  logic [31:0] status_in,
  input  logic [31:0] cause_in,
  input  logic [31:0] ssp_rdata,
  output logic        ssp_re,
  output logic        ssp_we,
  output logic [31:0] ssp_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] epc_out,
  output logic [31:0] status_out,
  output logic [31:0] cause_out,
  output logic        restore_valid,
  output logic        busy,
  output logic        done,
  output logic        ovf_err
);

  state_e      state_q, state_d;
  dir_e        dir_q, dir_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] sp_q, sp_d;
  logic        ovf_q, ovf_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] sts_q, sts_d;
  logic [31:0] cau_q, cau_d;
  logic        re_q, re_d;
  logic        we_q, we_d;
  logic [31:0] wd_q, wd_d;
  logic        req_q, req_d;
  logic        mwe_q, mwe_d;
  logic        done_q, done_d;
  logic        rv_q, rv_d;
  logic        busy_q, busy_d;

  logic [31:0] ag_sp;
  logic [31:0] ag_addr;
  logic [31:0] ag_new_sp;
  logic        ag_err;

  // The live SSP is only valid during RD_SP; afterwards use the captured copy.
  assign ag_sp = (state_q == ST_RD_SP) ? ssp_rdata : sp_q;

  ssp_addr_gen u_addr_gen (
    .sp_i     (ag_sp),
    .idx_i    (idx_q),
    .dir_i    (dir_q),
    .addr_o   (ag_addr),
    .new_sp_o (ag_new_sp),
    .err_o    (ag_err)
  );

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    idx_d   = idx_q;
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    epc_d   = epc_q;
    sts_d   = sts_q;
    cau_d   = cau_q;
    unique case (state_q)
      ST_IDLE: begin
        if (exc_req) begin
          state_d = ST_RD_SP;
          dir_d   = DIR_SAVE;
          ovf_d   = 1'b0;
        end else if (eret_req) begin
          state_d = ST_RD_SP;
          dir_d   = DIR_RESTORE;
          ovf_d   = 1'b0;
        end
      end
      ST_RD_SP: begin
        sp_d  = ssp_rdata;
        idx_d = CTX_EPC;
        if (ag_err) begin
          ovf_d   = 1'b1;
          state_d = ST_DONE;
        end else if (dir_q == DIR_SAVE) begin
          state_d = ST_PUSH;
        end else begin
          state_d = ST_POP;
        end
      end
      ST_PUSH: begin
        if (mem_ack) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == CTX_CAUSE) state_d = ST_WR_SP;
        end
      end
      ST_POP: begin
        if (mem_ack) begin
          idx_d = idx_q + 2'd1;
          unique case (idx_q)
            2'd0:    cau_d = mem_rdata;
            2'd1:    sts_d = mem_rdata;
            default: epc_d = mem_rdata;
          endcase
          if (idx_q == 2'd2) state_d = ST_WR_SP;
        end
      end
      ST_WR_SP: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    re_d   = (state_d == ST_RD_SP);
    we_d   = (state_d == ST_WR_SP);
    wd_d   = we_d ? ag_new_sp : 32'd0;
    req_d  = (state_d == ST_PUSH) || (state_d == ST_POP);
    mwe_d  = (state_d == ST_PUSH);
    done_d = (state_d == ST_DONE);
    rv_d   = done_d && (dir_d == DIR_RESTORE) && !ovf_d;
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_SAVE;
      idx_q   <= 2'd0;
      sp_q    <= 32'd0;
      ovf_q   <= 1'b0;
      epc_q   <= 32'd0;
      sts_q   <= 32'd0;
      cau_q   <= 32'd0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      wd_q    <= 32'd0;
      req_q   <= 1'b0;
      mwe_q   <= 1'b0;
      done_q  <= 1'b0;
      rv_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      idx_q   <= idx_d;
      sp_q    <= sp_d;
      ovf_q   <= ovf_d;
      epc_q   <= epc_d;
      sts_q   <= sts_d;
      cau_q   <= cau_d;
      re_q    <= re_d;
      we_q    <= we_d;
      wd_q    <= wd_d;
      req_q   <= req_d;
      mwe_q   <= mwe_d;
      done_q  <= done_d;
      rv_q    <= rv_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    mem_wdata = 32'd0;
    if (state_q == ST_PUSH) begin
      unique case (idx_q)
        2'd0:    mem_wdata = epc_in;
        2'd1:    mem_wdata = status_in;
        default: mem_wdata = cause_in;
      endcase
    end
  end

  assign mem_addr      = req_q ? ag_addr : 32'd0;
  assign ssp_re        = re_q;
  assign ssp_we        = we_q;
  assign ssp_wdata     = wd_q;
  assign mem_req       = req_q;
  assign mem_we        = mwe_q;
  assign epc_out       = epc_q;
  assign status_out    = sts_q;
  assign cause_out     = cau_q;
  assign restore_valid = rv_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign ovf_err       = ovf_q;

endmodule

// File: doc/ssp_ctx_seq.md
# ssp_ctx_seq

Exception context save/restore sequencer that sits directly upstream of the system stack pointer unit in CP0. On exception entry it reads the SSP and pushes EPC, STATUS and CAUSE to memory below it, then writes the decremented SSP back. On ERET it pops the three words in reverse order and restores the SSP. It drives the SSP unit's read-enable, write-enable and write-data inputs and consumes its read data.

## Interface
- STACK_LIMIT, 32'h0000_1000, lowest legal byte address of the system stack (inclusive).
- STACK_TOP, 32'h0000_2000, SSP value of an empty stack; a pop may not move the SSP above it.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-low (rst=0 resets on the next rising edge).
- exc_req  in  1  request a context save; sampled only in IDLE.
- eret_req  in  1  request a context restore; sampled only in IDLE.
- epc_in, status_in, cause_in  in  32 each  context words to save; sampled in the PUSH cycle that writes them.
- ssp_rdata  in  32  SSP value from the SSP unit; combinational and valid whenever ssp_re=1.
- ssp_re  out  1  read enable to the SSP unit.
- ssp_we  out  1  write enable to the SSP unit.
- ssp_wdata  out  32  new SSP value.
- mem_req, mem_we  out  1  memory request and write qualifier.
- mem_addr, mem_wdata  out  32  word address and write data.
- mem_ack  in  1  memory accept; may arrive in the same cycle as mem_req.
- mem_rdata  in  32  read data, valid with mem_ack.
- epc_out, status_out, cause_out  out  32  restored context registers.
- restore_valid  out  1  one-cycle pulse; restored registers are valid.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse (success or error).
- ovf_err  out  1  sticky bounds error; cleared when the next request is accepted.

## Operation
- **States:** IDLE, RD_SP, PUSH, POP, WR_SP, DONE.
- **IDLE:**
  - exc_req=1 → RD_SP (save).
  - eret_req=1 with exc_req=0 → RD_SP (restore).
  - Both high: save wins; eret_req is dropped, not queued.
- **RD_SP:**
  - ssp_re=1 for one cycle; sp is captured from ssp_rdata; idx is set to 0.
  - Bounds check, save: sp < STACK_LIMIT+12, evaluated at 33 bits.
  - Bounds check, restore: sp+12 > STACK_TOP, evaluated at 33 bits.
  - Any misalignment (sp[1:0]≠0) is also an error.
  - On error: go to DONE with ovf_err=1; no memory access and no SSP write.
  - Otherwise: go to PUSH (save) or POP (restore).
- **PUSH:**
  - mem_req=1, mem_we=1, mem_addr=sp−4*(idx+1).
  - mem_wdata is EPC for idx=0, STATUS for idx=1, CAUSE for idx=2.
  - req, addr and data hold stable until mem_ack; on ack idx increments.
  - After the ack with idx=2 → WR_SP with ssp_wdata=sp−12.
- **POP:**
  - mem_req=1, mem_we=0, mem_addr=sp+4*idx.
  - On ack, mem_rdata loads CAUSE (idx=0), STATUS (idx=1), EPC (idx=2).
  - After the ack with idx=2 → WR_SP with ssp_wdata=sp+12.
- **WR_SP:** ssp_we=1 for exactly one cycle → DONE.
- **DONE:** done=1 for one cycle; restore_valid=1 as well on a successful restore → IDLE.
- **Arithmetic:** address arithmetic is 32-bit modulo; wrap is impossible when the bounds check is enabled.
- **Reset mid-operation:**
  - Aborts immediately; mem_req drops next cycle and the SSP is never written, so the stack pointer is unchanged.
  - Partially written stack words are don't-care.
- **Reset values:** state IDLE; every output 0, including epc_out, status_out, cause_out and ovf_err.

## Timing
- **Zero-wait save:** request sampled at edge E0; RD_SP in cycle 1; PUSH in cycles 2–4; WR_SP in cycle 5; done in cycle 6. IDLE is re-entered in cycle 7.
- **Zero-wait restore:** identical; restore_valid coincides with done.
- **Wait states:** each cycle without mem_ack adds one cycle of latency.
- **Error path:** done in cycle 2.
- **Back-to-back:** a request held high is accepted again in the first IDLE cycle.
- **Outputs:** all are registered except mem_wdata and mem_addr, which are decoded from registered state, idx and sp.

## Configuration
- SSP_BOUNDS_CHECK_EN defined: bounds and alignment checks as above.
- SSP_BOUNDS_CHECK_EN undefined:
  - The checks are removed and ovf_err is tied to 0.
  - RD_SP always proceeds to PUSH/POP; addresses wrap modulo 2^32.
  - STACK_LIMIT and STACK_TOP are unused.

## Structure
- **Shared package cp0_pkg:**
  - state enumeration;
  - WORD_BYTES=4, CTX_WORDS=3, CTX_BYTES=12;
  - context index constants CTX_EPC=0, CTX_STATUS=1, CTX_CAUSE=2.
- **Sub-module ssp_addr_gen (combinational):**
  - inputs sp, idx, direction;
  - outputs mem_addr, new SSP value, bounds error.

## Test plan
- **Save:** reset, SSP=0x1800, exc_req with epc=0xBFC0_0100, status=0x0000_FF01, cause=0x0000_0030, zero-wait ack → writes 0x17FC=EPC, 0x17F8=STATUS, 0x17F4=CAUSE; ssp_we with 0x17F4 in cycle 5; done in cycle 6.
- **Restore:** after the save, eret_req with SSP=0x17F4 → reads 0x17F4, 0x17F8, 0x17FC; ssp_wdata=0x1800; epc_out=0xBFC0_0100 with restore_valid.
- **Wait states:** mem_ack delayed 2 cycles on every access → mem_addr and mem_wdata stay stable; done in cycle 12.
- **Overflow:** SSP=0x1008 on save → ovf_err=1 and done in cycle 2, with no mem_req and no ssp_we. A following valid request clears ovf_err. With the macro undefined, the save proceeds to 0x0FFC.
- **Simultaneous requests and reset:** exc_req and eret_req both high → save performed. rst=0 asserted during PUSH idx=1 → the next cycle shows IDLE, all outputs 0 and ssp_we never asserted.
